dual_stepper_pulser: RTL and testbench

Consumes the per-move step counts and directions produced by the SCARA motion controller and turns them into STEP/DIR waveforms for two external stepper drivers. It sits between the controller's `steps1/steps2/dir1/dir2/dataReady` outputs and the driver pins, and returns `stepperReady` to the controller. Both axes run in the same step period, so a move starts and ends on both joints together.

---
 rtl/stepper_pkg.sv | 14 +
 rtl/pulse_timer.sv | 26 ++
 rtl/dual_stepper_pulser.sv | 206 ++++++++++++++++++++
 tb/tb_dual_stepper_pulser.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// Shared types and constants for the dual-axis STEP/DIR pulse generator.
package stepper_pkg;

    localparam int STEP_TIMER_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        DONE
    } stepper_state_t;

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter; expire is high whenever the count has reached zero.
module pulse_timer
    import stepper_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [STEP_TIMER_W-1:0] value,
    output logic                    expire
);

    logic [STEP_TIMER_W-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= value;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign expire = (count_reg == '0);

endmodule

// File: rtl/dual_stepper_pulser.sv
// Two-axis STEP/DIR generator sharing one step period; both joints start and end together.
// Define STEPPER_LINEAR_INTERP_EN for Bresenham spreading of the minor axis pulses.
module dual_stepper_pulser
    import stepper_pkg::*;
#(
    parameter int DIR_SETUP_CYCLES  = 50,
    parameter int PULSE_HIGH_CYCLES = 100,
    parameter int PULSE_LOW_CYCLES  = 400
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] steps1,
    input  logic [7:0] steps2,
    input  logic       dir1,
    input  logic       dir2,
    input  logic       dataReady,
    input  logic       halt,
    output logic       step1,
    output logic       step2,
    output logic       dirOut1,
    output logic       dirOut2,
    output logic       stepperReady,
    output logic       moveDone
);

    // Timer is loaded with N-1 so that a phase lasts exactly N clocks.
    localparam logic [STEP_TIMER_W-1:0] SETUP_LOAD = STEP_TIMER_W'(DIR_SETUP_CYCLES - 1);
    localparam logic [STEP_TIMER_W-1:0] HIGH_LOAD  = STEP_TIMER_W'(PULSE_HIGH_CYCLES - 1);
    localparam logic [STEP_TIMER_W-1:0] LOW_LOAD   = STEP_TIMER_W'(PULSE_LOW_CYCLES - 1);

    stepper_state_t          state_reg, state_next;
    logic                    dr_prev_reg;
    logic [7:0]              cnt_reg, cnt_next;
    logic                    halt_seen_reg, halt_seen_next;
    logic                    step1_reg, step1_next, step2_reg, step2_next;
    logic                    dir1_reg, dir2_reg;
    logic                    accept, period_start;
    logic                    sel1, sel2;
    logic                    timer_load, timer_expire;
    logic [STEP_TIMER_W-1:0] timer_value;
    logic [7:0]              max_in;

    assign accept = (state_reg == IDLE) && dataReady && !dr_prev_reg;
    assign max_in = (steps1 >= steps2) ? steps1 : steps2;

    pulse_timer u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (timer_load),
        .value  (timer_value),
        .expire (timer_expire)
    );

`ifdef STEPPER_LINEAR_INTERP_EN
    logic [8:0] acc_reg, acc_sum, acc_next;
    logic [7:0] major_reg, minor_reg;
    logic       major1_reg, minor_hit;

    always_comb begin
        acc_sum   = acc_reg + {1'b0, minor_reg};
        minor_hit = (acc_sum >= {1'b0, major_reg});
        acc_next  = minor_hit ? (acc_sum - {1'b0, major_reg}) : acc_sum;
        sel1      = major1_reg ? 1'b1 : minor_hit;
        sel2      = major1_reg ? minor_hit : 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_reg    <= '0;
            major_reg  <= '0;
            minor_reg  <= '0;
            major1_reg <= 1'b1;
        end else if (accept) begin
            acc_reg    <= '0;
            major1_reg <= (steps1 >= steps2);
            major_reg  <= (steps1 >= steps2) ? steps1 : steps2;
            minor_reg  <= (steps1 >= steps2) ? steps2 : steps1;
        end else if (period_start) begin
            acc_reg    <= acc_next;
        end
    end
`else
    logic [7:0] rem1_reg, rem2_reg;

    always_comb begin
        sel1 = (rem1_reg != '0);
        sel2 = (rem2_reg != '0);
    end

    // Each axis steps in the first n periods of the move.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem1_reg <= '0;
            rem2_reg <= '0;
        end else if (accept) begin
            rem1_reg <= steps1;
            rem2_reg <= steps2;
        end else if (period_start) begin
            if (sel1) rem1_reg <= rem1_reg - 1'b1;
            if (sel2) rem2_reg <= rem2_reg - 1'b1;
        end
    end
`endif

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        halt_seen_next = halt_seen_reg;
        step1_next     = step1_reg;
        step2_next     = step2_reg;
        timer_load     = 1'b0;
        timer_value    = '0;
        period_start   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    cnt_next       = max_in;
                    halt_seen_next = 1'b0;
                    if (max_in == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next  = SETUP;
                        timer_load  = 1'b1;
                        timer_value = SETUP_LOAD;
                    end
                end
            end
            SETUP: begin
                if (halt) begin
                    state_next = DONE;
                end else if (timer_expire) begin
                    state_next   = HIGH;
                    timer_load   = 1'b1;
                    timer_value  = HIGH_LOAD;
                    period_start = 1'b1;
                end
            end
            HIGH: begin
                halt_seen_next = halt_seen_reg | halt;
                if (timer_expire) begin
                    state_next  = LOW;
                    timer_load  = 1'b1;
                    timer_value = LOW_LOAD;
                    step1_next  = 1'b0;
                    step2_next  = 1'b0;
                end
            end
            LOW: begin
                halt_seen_next = halt_seen_reg | halt;
                if (timer_expire) begin
                    cnt_next = cnt_reg - 1'b1;
                    if ((cnt_reg == 8'd1) || halt_seen_reg || halt) begin
                        state_next = DONE;
                    end else begin
                        state_next   = HIGH;
                        timer_load   = 1'b1;
                        timer_value  = HIGH_LOAD;
                        period_start = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next     = IDLE;
                halt_seen_next = 1'b0;
            end
            default: state_next = IDLE;
        endcase
        if (period_start) begin
            step1_next = sel1;
            step2_next = sel2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            dr_prev_reg   <= 1'b0;
            cnt_reg       <= '0;
            halt_seen_reg <= 1'b0;
            step1_reg     <= 1'b0;
            step2_reg     <= 1'b0;
            dir1_reg      <= 1'b0;
            dir2_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            dr_prev_reg   <= dataReady;
            cnt_reg       <= cnt_next;
            halt_seen_reg <= halt_seen_next;
            step1_reg     <= step1_next;
            step2_reg     <= step2_next;
            if (accept) begin
                dir1_reg <= dir1;
                dir2_reg <= dir2;
            end
        end
    end

    assign step1        = step1_reg;
    assign step2        = step2_reg;
    assign dirOut1      = dir1_reg;
    assign dirOut2      = dir2_reg;
    assign stepperReady = (state_reg == IDLE);
    assign moveDone     = (state_reg == DONE);

endmodule

// File: tb/tb_dual_stepper_pulser.sv
// Directed bench for dual_stepper_pulser with S=2, H=3, L=4 (period of 7 clocks).
// Interpolated expectations apply when STEPPER_LINEAR_INTERP_EN is defined.
module tb_dual_stepper_pulser;

    localparam int S = 2;
    localparam int H = 3;
    localparam int L = 4;
    localparam int P = H + L;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] steps1 = '0, steps2 = '0;
    logic       dir1 = 1'b0, dir2 = 1'b0;
    logic       dataReady = 1'b0, halt = 1'b0;
    logic       step1, step2, dirOut1, dirOut2, stepperReady, moveDone;

    int n_cmp = 0;
    int n_bad = 0;

    logic s1_log [0:79];
    logic s2_log [0:79];
    logic d1_log [0:79];
    logic d2_log [0:79];
    logic rdy_log[0:79];
    logic done_log[0:79];

    always #5 clk = ~clk;

    dual_stepper_pulser #(
        .DIR_SETUP_CYCLES  (S),
        .PULSE_HIGH_CYCLES (H),
        .PULSE_LOW_CYCLES  (L)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .steps1       (steps1),
        .steps2       (steps2),
        .dir1         (dir1),
        .dir2         (dir2),
        .dataReady    (dataReady),
        .halt         (halt),
        .step1        (step1),
        .step2        (step2),
        .dirOut1      (dirOut1),
        .dirOut2      (dirOut2),
        .stepperReady (stepperReady),
        .moveDone     (moveDone)
    );

    // Expected STEP level j cycles after the acceptance edge; mask bit k = axis pulses in period k.
    function automatic logic exp_pulse(input int j, input int nper, input logic [15:0] mask);
        int k, ph;
        if (j < S) return 1'b0;
        k  = (j - S) / P;
        ph = (j - S) % P;
        return (k < nper) && mask[k] && (ph < H);
    endfunction

    task automatic start_move(input logic [7:0] a, input logic [7:0] b, input logic d1, input logic d2);
        @(negedge clk);
        steps1 = a; steps2 = b; dir1 = d1; dir2 = d2;
        dataReady = 1'b1;
    endtask

    // Sample index j is taken at the falling edge after acceptance edge E0+j.
    task automatic capture(input int len);
        for (int j = 0; j < len; j++) begin
            @(negedge clk);
            s1_log[j] = step1; s2_log[j] = step2;
            d1_log[j] = dirOut1; d2_log[j] = dirOut2;
            rdy_log[j] = stepperReady; done_log[j] = moveDone;
        end
    endtask

    task automatic finish_move();
        dataReady = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({step1, step2, dirOut1, dirOut2, stepperReady, moveDone} !== 6'b000010) begin
            n_bad++;
            $display("FAIL reset_state: got %b expected 000010",
                     {step1, step2, dirOut1, dirOut2, stepperReady, moveDone});
        end
        $display("test_reset: outputs=%b", {step1, step2, dirOut1, dirOut2, stepperReady, moveDone});
    endtask

    task automatic test_reset_mid_pulse();
        start_move(8'd3, 8'd0, 1'b1, 1'b1);
        capture(S + 2);
        n_cmp++;
        if (step1 !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reset_pre_step1: got %b expected 1", step1);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({step1, stepperReady, dirOut1} !== 3'b010) begin
            n_bad++;
            $display("FAIL mid_reset_async: step1/rdy/dir1 got %b expected 010", {step1, stepperReady, dirOut1});
        end
        dataReady = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        $display("test_reset_mid_pulse: step1=%b rdy=%b", step1, stepperReady);
    endtask

    task automatic test_no_interp_move();
        start_move(8'd5, 8'd3, 1'b1, 1'b0);
        capture(40);
        for (int j = 0; j < 40; j++) begin
            n_cmp++;
            if (s1_log[j] !== exp_pulse(j, 5, 16'h001f) || s2_log[j] !== exp_pulse(j, 5, 16'h0007)) begin
                n_bad++;
                $display("FAIL move53_steps j=%0d: got %b%b expected %b%b", j, s1_log[j], s2_log[j],
                         exp_pulse(j, 5, 16'h001f), exp_pulse(j, 5, 16'h0007));
            end
            n_cmp++;
            if (d1_log[j] !== 1'b1 || d2_log[j] !== 1'b0) begin
                n_bad++;
                $display("FAIL move53_dir j=%0d: got %b%b expected 10", j, d1_log[j], d2_log[j]);
            end
            n_cmp++;
            if (done_log[j] !== (j == 37) || rdy_log[j] !== (j >= 38)) begin
                n_bad++;
                $display("FAIL move53_done_rdy j=%0d: got %b%b expected %b%b", j, done_log[j], rdy_log[j],
                         (j == 37), (j >= 38));
            end
        end
        finish_move();
        $display("test_no_interp_move: 5/3 steps done at E0+37");
    endtask

    task automatic test_interp_move();
        logic [15:0] m2;
`ifdef STEPPER_LINEAR_INTERP_EN
        m2 = 16'h000a;
`else
        m2 = 16'h0003;
`endif
        start_move(8'd4, 8'd2, 1'b0, 1'b1);
        capture(32);
        for (int j = 0; j < 32; j++) begin
            n_cmp++;
            if (s1_log[j] !== exp_pulse(j, 4, 16'h000f) || s2_log[j] !== exp_pulse(j, 4, m2)) begin
                n_bad++;
                $display("FAIL move42_steps j=%0d: got %b%b expected %b%b", j, s1_log[j], s2_log[j],
                         exp_pulse(j, 4, 16'h000f), exp_pulse(j, 4, m2));
            end
            n_cmp++;
            if (done_log[j] !== (j == 30) || rdy_log[j] !== (j >= 31)) begin
                n_bad++;
                $display("FAIL move42_done_rdy j=%0d: got %b%b expected %b%b", j, done_log[j], rdy_log[j],
                         (j == 30), (j >= 31));
            end
        end
        finish_move();
        $display("test_interp_move: 4/2 steps, step2 mask %h", m2);
    endtask

    task automatic test_zero_move();
        start_move(8'd0, 8'd0, 1'b1, 1'b1);
        capture(4);
        for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (s1_log[j] !== 1'b0 || s2_log[j] !== 1'b0 || done_log[j] !== (j == 0) || rdy_log[j] !== (j >= 1)) begin
                n_bad++;
                $display("FAIL zero_move j=%0d: step=%b%b done=%b rdy=%b expected step=00 done=%b rdy=%b",
                         j, s1_log[j], s2_log[j], done_log[j], rdy_log[j], (j == 0), (j >= 1));
            end
        end
        finish_move();
        $display("test_zero_move: done at E0");
    endtask

    task automatic test_held_data_ready();
        int pulses, dones;
        start_move(8'd2, 8'd1, 1'b0, 1'b0);
        capture(40);
        pulses = 0; dones = 0;
        for (int j = 0; j < 40; j++) begin
            if (s1_log[j] && (j == 0 || !s1_log[j-1])) pulses++;
            if (done_log[j]) dones++;
        end
        n_cmp++;
        if (pulses !== 2 || dones !== 1) begin
            n_bad++;
            $display("FAIL held_dr_single_move: pulses=%0d dones=%0d expected 2 and 1", pulses, dones);
        end
        n_cmp++;
        if (done_log[16] !== 1'b1 || rdy_log[39] !== 1'b1) begin
            n_bad++;
            $display("FAIL held_dr_timing: done@16=%b rdy@39=%b expected 1 1", done_log[16], rdy_log[39]);
        end
        dataReady = 1'b0;
        @(negedge clk);
        dataReady = 1'b1;
        capture(3);
        n_cmp++;
        if (rdy_log[0] !== 1'b0 || s1_log[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL held_dr_second_move: rdy@0=%b step1@2=%b expected 0 1", rdy_log[0], s1_log[2]);
        end
        capture(20);
        finish_move();
        $display("test_held_data_ready: pulses=%0d dones=%0d", pulses, dones);
    endtask

    task automatic test_halt();
        int pulses;
        start_move(8'd10, 8'd10, 1'b1, 1'b0);
        for (int j = 0; j < 24; j++) begin
            @(negedge clk);
            s1_log[j] = step1; s2_log[j] = step2;
            rdy_log[j] = stepperReady; done_log[j] = moveDone;
            halt = (j == S + P);
        end
        halt = 1'b0;
        pulses = 0;
        for (int j = 0; j < 24; j++) begin
            if (s1_log[j] && (j == 0 || !s1_log[j-1])) pulses++;
            n_cmp++;
            if (s1_log[j] !== exp_pulse(j, 2, 16'h0003) || s2_log[j] !== exp_pulse(j, 2, 16'h0003)) begin
                n_bad++;
                $display("FAIL halt_steps j=%0d: got %b%b expected %b%b", j, s1_log[j], s2_log[j],
                         exp_pulse(j, 2, 16'h0003), exp_pulse(j, 2, 16'h0003));
            end
            n_cmp++;
            if (done_log[j] !== (j == 16) || rdy_log[j] !== (j >= 17)) begin
                n_bad++;
                $display("FAIL halt_done_rdy j=%0d: got %b%b expected %b%b", j, done_log[j], rdy_log[j],
                         (j == 16), (j >= 17));
            end
        end
        finish_move();
        $display("test_halt: pulses=%0d", pulses);
    endtask

    initial begin
        test_reset();
        test_reset_mid_pulse();
        test_no_interp_move();
        test_interp_move();
        test_zero_move();
        test_held_data_ready();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
